// File: rtl/legv8_phase_sequencer.sv
// rtl/legv8_phase_sequencer.sv - multicycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK phase sequencer for the LEGv8 core
//
// Ports:
//   clk, rst_n                         core clock (rising edge), asynchronous active-low reset
//   start_in                           loader start pulse, honoured only in IDLE
//   imem_ready_in, dmem_ready_in       memory handshake completions
//   zero_flag_in                       ALU zero flag, sampled in EXECUTE
//   reg_write_in .. halt_in            decoder control bits, captured in DECODE
//   imem_req_out, ir_write_out         instruction fetch request / IR load pulse
//   dmem_req_out, dmem_we_out          data access request / write enable
//   rf_write_out, link_sel_out         register-file write strobe / select PC+4 as write data
//   pc_write_out, pc_src_out           PC update strobe / PC source (00 PC+4, 01 branch, 10 register)
//   busy_out, halted_out, fault_out    status
//   instret_out                        retired-instruction counter

module legv8_phase_sequencer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_in,
    input  logic                 imem_ready_in,
    input  logic                 dmem_ready_in,
    input  logic                 zero_flag_in,
    input  logic                 reg_write_in,
    input  logic                 mem_read_in,
    input  logic                 mem_write_in,
    input  logic                 uncond_branch_in,
    input  logic                 cond_branch_in,
    input  logic                 is_cbz_in,
    input  logic                 is_cbnz_in,
    input  logic                 branch_reg_in,
    input  logic                 branch_link_in,
    input  logic                 halt_in,
    output logic                 imem_req_out,
    output logic                 ir_write_out,
    output logic                 dmem_req_out,
    output logic                 dmem_we_out,
    output logic                 rf_write_out,
    output logic                 link_sel_out,
    output logic                 pc_write_out,
    output logic [1:0]           pc_src_out,
    output logic                 busy_out,
    output logic                 halted_out,
    output logic                 fault_out,
    output logic [CNT_WIDTH-1:0] instret_out
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALTED,
        S_FAULT
    } state_t;

    state_t         state, state_next;
    logic [TW-1:0]  tmo_cnt;
    logic           tmo_hit;
    logic           halt_retire;
    logic           branch_taken;

    // Decoder bits captured in DECODE; later phases never look at the live decoder.
    logic l_reg_write, l_mem_read, l_mem_write, l_uncond_branch, l_cond_branch;
    logic l_is_cbz, l_is_cbnz, l_branch_reg, l_branch_link, l_halt;

    assign tmo_hit      = (tmo_cnt == TW'(MEM_TIMEOUT - 1));
    assign branch_taken = (l_is_cbz & zero_flag_in) | (l_is_cbnz & ~zero_flag_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            l_reg_write     <= 1'b0;
            l_mem_read      <= 1'b0;
            l_mem_write     <= 1'b0;
            l_uncond_branch <= 1'b0;
            l_cond_branch   <= 1'b0;
            l_is_cbz        <= 1'b0;
            l_is_cbnz       <= 1'b0;
            l_branch_reg    <= 1'b0;
            l_branch_link   <= 1'b0;
            l_halt          <= 1'b0;
        end else if (state == S_DECODE) begin
            l_reg_write     <= reg_write_in;
            l_mem_read      <= mem_read_in;
            l_mem_write     <= mem_write_in;
            l_uncond_branch <= uncond_branch_in;
            l_cond_branch   <= cond_branch_in;
            l_is_cbz        <= is_cbz_in;
            l_is_cbnz       <= is_cbnz_in;
            l_branch_reg    <= branch_reg_in;
            l_branch_link   <= branch_link_in;
            l_halt          <= halt_in;
        end
    end

    // Counts consecutive stalled cycles of the active handshake; any other
    // cycle (including every state outside FETCH/MEM) clears it, so each
    // entry to FETCH or MEM starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if ((state == S_FETCH && !imem_ready_in) ||
                     (state == S_MEM   && !dmem_ready_in)) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_out <= '0;
        end else if (pc_write_out || halt_retire) begin
            instret_out <= instret_out + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_next   = state;
        imem_req_out = 1'b0;
        ir_write_out = 1'b0;
        dmem_req_out = 1'b0;
        dmem_we_out  = 1'b0;
        rf_write_out = 1'b0;
        link_sel_out = 1'b0;
        pc_write_out = 1'b0;
        pc_src_out   = 2'b00;
        halt_retire  = 1'b0;

        case (state)
            S_IDLE: begin
                if (start_in) begin
                    state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                imem_req_out = 1'b1;
                if (imem_ready_in) begin
                    ir_write_out = 1'b1;
                    state_next   = S_DECODE;
                end else if (tmo_hit) begin
                    state_next = S_FAULT;
                end
            end
            S_DECODE: begin
                state_next = S_EXECUTE;
            end
            S_EXECUTE: begin
                // Priority order matters: BL carries uncond_branch and must
                // reach WRITEBACK, and a combined load/store is a store.
                if (l_halt) begin
                    halt_retire = 1'b1;
                    state_next  = S_HALTED;
                end else if (l_cond_branch) begin
                    pc_write_out = 1'b1;
                    pc_src_out   = branch_taken ? 2'b01 : 2'b00;
                    state_next   = S_FETCH;
                end else if (l_uncond_branch && !l_branch_link) begin
                    pc_write_out = 1'b1;
                    pc_src_out   = l_branch_reg ? 2'b10 : 2'b01;
                    state_next   = S_FETCH;
                end else if (l_branch_link) begin
                    state_next = S_WRITEBACK;
                end else if (l_mem_read || l_mem_write) begin
                    state_next = S_MEM;
                end else if (l_reg_write) begin
                    state_next = S_WRITEBACK;
                end else begin
                    pc_write_out = 1'b1;
                    state_next   = S_FETCH;
                end
            end
            S_MEM: begin
                dmem_req_out = 1'b1;
                dmem_we_out  = l_mem_write;
                if (dmem_ready_in) begin
                    if (l_mem_write) begin
                        pc_write_out = 1'b1;
                        state_next   = S_FETCH;
                    end else begin
                        state_next = S_WRITEBACK;
                    end
                end else if (tmo_hit) begin
                    state_next = S_FAULT;
                end
            end
            S_WRITEBACK: begin
                rf_write_out = 1'b1;
                link_sel_out = l_branch_link;
                pc_write_out = 1'b1;
                pc_src_out   = l_branch_link ? 2'b01 : 2'b00;
                state_next   = S_FETCH;
            end
            S_HALTED: begin
                state_next = S_HALTED;
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign busy_out   = (state != S_IDLE) && (state != S_HALTED) && (state != S_FAULT);
    assign halted_out = (state == S_HALTED);
    assign fault_out  = (state == S_FAULT);

endmodule
